// File: rtl/gpio_debounce.sv
// Two-flop synchroniser, per-bit programmable debounce and edge pulses for the GPIO inputs.
// Define GPIO_DEB_IRQ_EN to build the sticky pending register and the irq output.
module gpio_debounce #(
    parameter int                GPIO_W    = 32,
    parameter int                DEB_CNT_W = 16,
    parameter logic [GPIO_W-1:0] RST_VAL   = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [GPIO_W-1:0]    gpio_pad,
    input  logic [DEB_CNT_W-1:0] cfg_deb_cycles,
    output logic [GPIO_W-1:0]    gpio_input,
    output logic [GPIO_W-1:0]    gpio_rise,
    output logic [GPIO_W-1:0]    gpio_fall,
    input  logic [GPIO_W-1:0]    irq_en,
    input  logic [GPIO_W-1:0]    irq_clr,
    output logic [GPIO_W-1:0]    irq_pend,
    output logic                 irq
);

    localparam logic [DEB_CNT_W:0]   ONE_X = (DEB_CNT_W+1)'(1);
    localparam logic [DEB_CNT_W-1:0] ONE   = DEB_CNT_W'(1);

    logic [GPIO_W-1:0]    sync_a;
    logic [GPIO_W-1:0]    sync_b;
    logic [GPIO_W-1:0]    stable;
    logic [GPIO_W-1:0]    rise_q;
    logic [GPIO_W-1:0]    fall_q;
    logic [GPIO_W-1:0]    cnt_hit;
    logic [DEB_CNT_W:0]   neff;
    logic [DEB_CNT_W-1:0] cnt [GPIO_W];

    // One extra bit keeps cnt+1 from wrapping when cfg is all ones.
    always_comb begin
        neff    = (cfg_deb_cycles == '0) ? ONE_X : {1'b0, cfg_deb_cycles};
        cnt_hit = '0;
        for (int i = 0; i < GPIO_W; i++) begin
            cnt_hit[i] = (({1'b0, cnt[i]} + ONE_X) >= neff);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_a <= RST_VAL;
            sync_b <= RST_VAL;
        end else begin
            sync_a <= gpio_pad;
            sync_b <= sync_a;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= RST_VAL;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < GPIO_W; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < GPIO_W; i++) begin
                if (sync_b[i] == stable[i]) begin
                    cnt[i]    <= '0;
                    rise_q[i] <= 1'b0;
                    fall_q[i] <= 1'b0;
                end else if (cnt_hit[i]) begin
                    stable[i] <= sync_b[i];
                    cnt[i]    <= '0;
                    rise_q[i] <= sync_b[i];
                    fall_q[i] <= ~sync_b[i];
                end else begin
                    cnt[i]    <= cnt[i] + ONE;
                    rise_q[i] <= 1'b0;
                    fall_q[i] <= 1'b0;
                end
            end
        end
    end

    assign gpio_input = stable;
    assign gpio_rise  = rise_q;
    assign gpio_fall  = fall_q;

`ifdef GPIO_DEB_IRQ_EN
    logic [GPIO_W-1:0] pend_q;

    // A new edge in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~irq_clr) | (irq_en & (rise_q | fall_q));
        end
    end

    assign irq_pend = pend_q;
    assign irq      = |pend_q;
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{irq_en, irq_clr};
    assign irq_pend = '0;
    assign irq      = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// Bench for gpio_debounce: directed vector table, hand-written corner sequences and
// randomized traffic checked against a run-length reference model.
module tb_gpio_debounce;

    localparam int W  = 32;
    localparam int CW = 16;
`ifdef GPIO_DEB_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic [W-1:0]  gpio_pad;
    logic [CW-1:0] cfg_deb_cycles;
    logic [W-1:0]  gpio_input;
    logic [W-1:0]  gpio_rise;
    logic [W-1:0]  gpio_fall;
    logic [W-1:0]  irq_en;
    logic [W-1:0]  irq_clr;
    logic [W-1:0]  irq_pend;
    logic          irq;

    int checks = 0;
    int errors = 0;

    gpio_debounce dut (
        .clk            (clk),
        .rst            (rst),
        .gpio_pad       (gpio_pad),
        .cfg_deb_cycles (cfg_deb_cycles),
        .gpio_input     (gpio_input),
        .gpio_rise      (gpio_rise),
        .gpio_fall      (gpio_fall),
        .irq_en         (irq_en),
        .irq_clr        (irq_clr),
        .irq_pend       (irq_pend),
        .irq            (irq)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // reference model: a level must be seen (two edges late) for neff consecutive edges
    typedef struct {
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic [W-1:0] pend;
        logic [W-1:0] h1;
        logic [W-1:0] h2;
        int           run [W];
    } mstate_t;

    mstate_t m;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.stable = '0;
        r.rise   = '0;
        r.fall   = '0;
        r.pend   = '0;
        r.h1     = '0;
        r.h2     = '0;
        for (int i = 0; i < W; i++) r.run[i] = 0;
        return r;
    endfunction

    function automatic mstate_t model_next(mstate_t s, logic [W-1:0] pad, logic [CW-1:0] cfg,
                                           logic [W-1:0] en, logic [W-1:0] clr);
        mstate_t r;
        int      neff;
        r    = s;
        neff = (cfg == 0) ? 1 : int'(cfg);
        if (IRQ_ON) r.pend = (s.pend & ~clr) | (en & (s.rise | s.fall));
        else        r.pend = '0;
        r.rise = '0;
        r.fall = '0;
        for (int i = 0; i < W; i++) begin
            if (s.h2[i] != s.stable[i]) begin
                r.run[i] = s.run[i] + 1;
                if (r.run[i] >= neff) begin
                    r.stable[i] = s.h2[i];
                    r.rise[i]   = s.h2[i];
                    r.fall[i]   = ~s.h2[i];
                    r.run[i]    = 0;
                end
            end else begin
                r.run[i] = 0;
            end
        end
        r.h2 = s.h1;
        r.h1 = pad;
        return r;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) m <= model_reset();
        else      m <= model_next(m, gpio_pad, cfg_deb_cycles, irq_en, irq_clr);
    end

    // scoreboard against the model, every cycle out of reset
    always @(negedge clk) begin
        if (rst) begin
            check("model_input", gpio_input, m.stable);
            check("model_rise",  gpio_rise,  m.rise);
            check("model_fall",  gpio_fall,  m.fall);
            check("model_pend",  irq_pend,   m.pend);
            check("model_irq",   W'(irq),    W'(|m.pend));
        end
    end

    typedef struct {
        logic [W-1:0]  pad;
        logic [CW-1:0] cfg;
        logic [W-1:0]  en;
        logic [W-1:0]  clr;
        logic [W-1:0]  e_in;
        logic [W-1:0]  e_rise;
        logic [W-1:0]  e_fall;
        logic [W-1:0]  e_pend;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic [W-1:0] pad, input logic [W-1:0] clr,
                       input logic [W-1:0] e_in, input logic [W-1:0] e_rise,
                       input logic [W-1:0] e_fall, input logic [W-1:0] e_pend);
        vec_t v;
        v.pad = pad; v.cfg = CW'(4); v.en = 32'h1; v.clr = clr;
        v.e_in = e_in; v.e_rise = e_rise; v.e_fall = e_fall; v.e_pend = e_pend;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endtask

    initial begin
        logic [W-1:0] pend_exp;
        rst            = 1'b0;
        gpio_pad       = '0;
        cfg_deb_cycles = CW'(4);
        irq_en         = 32'h1;
        irq_clr        = '0;

        // bit0 rise, bit1 rise without enable, clear, then bit0 fall with clear on the pulse cycle
        add(5, 32'h1, 0, 32'h0, 0, 0, 0);
        add(1, 32'h1, 0, 32'h1, 32'h1, 0, 0);
        add(2, 32'h1, 0, 32'h1, 0, 0, 32'h1);
        add(5, 32'h3, 0, 32'h1, 0, 0, 32'h1);
        add(1, 32'h3, 0, 32'h3, 32'h2, 0, 32'h1);
        add(1, 32'h3, 0, 32'h3, 0, 0, 32'h1);
        add(1, 32'h3, 32'h1, 32'h3, 0, 0, 0);
        add(1, 32'h3, 0, 32'h3, 0, 0, 0);
        add(5, 32'h2, 0, 32'h3, 0, 0, 0);
        add(1, 32'h2, 0, 32'h2, 0, 32'h1, 0);
        add(1, 32'h2, 32'h1, 32'h2, 0, 0, 32'h1);
        add(1, 32'h2, 0, 32'h2, 0, 0, 32'h1);
        add(1, 32'h2, 32'h1, 32'h2, 0, 0, 0);
        add(1, 32'h2, 0, 32'h2, 0, 0, 0);

        #12;
        check("reset_input", gpio_input, '0);
        check("reset_edges", gpio_rise | gpio_fall, '0);
        check("reset_pend",  irq_pend, '0);
        check("reset_irq",   W'(irq), '0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            gpio_pad       = vecs[i].pad;
            cfg_deb_cycles = vecs[i].cfg;
            irq_en         = vecs[i].en;
            irq_clr        = vecs[i].clr;
            tick();
            pend_exp = IRQ_ON ? vecs[i].e_pend : '0;
            check($sformatf("vec%0d_input", i), gpio_input, vecs[i].e_in);
            check($sformatf("vec%0d_rise", i),  gpio_rise,  vecs[i].e_rise);
            check($sformatf("vec%0d_fall", i),  gpio_fall,  vecs[i].e_fall);
            check($sformatf("vec%0d_pend", i),  irq_pend,   pend_exp);
            check($sformatf("vec%0d_irq", i),   W'(irq),    W'(|pend_exp));
        end
        irq_clr = '0;
        irq_en  = '0;

        // bit3: 3-cycle glitch rejected, 4-cycle pulse accepted
        for (int t = 0; t < 11; t++) begin
            gpio_pad = (t < 3) ? 32'hA : 32'h2;
            tick();
            check("glitch_input", gpio_input, 32'h2);
            check("glitch_edges", gpio_rise | gpio_fall, '0);
        end
        for (int t = 0; t < 10; t++) begin
            gpio_pad = (t < 4) ? 32'hA : 32'h2;
            tick();
            if (t < 5) check("pulse4_before", gpio_input, 32'h2);
            if (t == 5) begin
                check("pulse4_input", gpio_input, 32'hA);
                check("pulse4_rise",  gpio_rise,  32'h8);
            end
            if (t == 9) begin
                check("pulse4_fall_in", gpio_input, 32'h2);
                check("pulse4_fall",    gpio_fall,  32'h8);
            end
        end

        // cfg=0 behaves as 1: bit5 falls at the third edge
        cfg_deb_cycles = '0;
        gpio_pad       = 32'h22;
        for (int t = 0; t < 4; t++) tick();
        check("cfg0_high", gpio_input, 32'h22);
        gpio_pad = 32'h02;
        tick();
        check("cfg0_e1", gpio_input, 32'h22);
        tick();
        check("cfg0_e2", gpio_input, 32'h22);
        tick();
        check("cfg0_e3_input", gpio_input, 32'h02);
        check("cfg0_e3_fall",  gpio_fall,  32'h20);

        // reset mid-count: bit0 stable high and pending, bit2 counting at cnt=5
        cfg_deb_cycles = CW'(4);
        irq_en         = 32'h1;
        gpio_pad       = 32'h1;
        for (int t = 0; t < 8; t++) tick();
        cfg_deb_cycles = CW'(8);
        gpio_pad       = 32'h5;
        for (int t = 0; t < 7; t++) tick();
        check("pre_reset_input", gpio_input, 32'h1);
        check("pre_reset_pend",  irq_pend, IRQ_ON ? 32'h1 : '0);
        #2 rst = 1'b0;
        #1;
        check("async_reset_input", gpio_input, '0);
        check("async_reset_edges", gpio_rise | gpio_fall, '0);
        check("async_reset_pend",  irq_pend, '0);
        check("async_reset_irq",   W'(irq), '0);
        @(negedge clk);
        #2 rst = 1'b1;
        for (int t = 0; t < 9; t++) tick();
        check("post_reset_e9", gpio_input, '0);
        tick();
        check("post_reset_e10_input", gpio_input, 32'h5);
        check("post_reset_e10_rise",  gpio_rise,  32'h5);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if ((c % 60) == 0) cfg_deb_cycles = CW'($urandom_range(0, 5));
            gpio_pad = gpio_pad ^ ($urandom & $urandom & $urandom & $urandom);
            irq_en   = ((c / 100) % 2 == 1) ? 32'hFFFF_FFFF : $urandom;
            irq_clr  = $urandom & $urandom & $urandom;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
